// File: rtl/pfa_pkg.sv
// rtl/pfa_pkg.sv - shared helpers, stage mapping and payload fragments for the pipelined prefix adder
package pfa_pkg;

  typedef struct packed {
    logic a_msb;
    logic b_msb;
  } pfa_msb_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int levels_per_stage(input int width, input int stages);
    return (clog2(width) + stages - 1) / stages;
  endfunction

  function automatic int stage_of_level(input int lvl, input int lps);
    return lvl / lps;
  endfunction

  function automatic bit params_ok(input int width, input int stages, input int tag_w);
    return (width >= 4) && (width <= 64) && ((width & (width - 1)) == 0) &&
           (stages >= 1) && (stages <= clog2(width) + 1) && (tag_w >= 1);
  endfunction

endpackage

// File: rtl/pfa_prefix_level.sv
// rtl/pfa_prefix_level.sv - one combinational Kogge-Stone (g,p) combine level at a fixed distance
module pfa_prefix_level #(
  parameter int N    = 32,
  parameter int DIST = 1
) (
  input  logic [N-1:0] i_g,
  input  logic [N-1:0] i_p,
  output logic [N-1:0] o_g,
  output logic [N-1:0] o_p
);

  assign o_g[DIST-1:0] = i_g[DIST-1:0];
  assign o_p[DIST-1:0] = i_p[DIST-1:0];
  assign o_g[N-1:DIST] = i_g[N-1:DIST] | (i_p[N-1:DIST] & i_g[N-1-DIST:0]);
  assign o_p[N-1:DIST] = i_p[N-1:DIST] & i_p[N-1-DIST:0];

endmodule

// File: rtl/pfa_pipe.sv
// rtl/pfa_pipe.sv - pipelined Kogge-Stone add/sub with overflow flag, tag sideband and global-stall flow control
module pfa_pipe
  import pfa_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int LPS    = levels_per_stage(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES, TAG_W)) begin : g_bad_params
    $error("pfa_pipe: illegal WIDTH/STAGES/TAG_W combination");
  end

  // Index 0 of g/p is the carry-in slot; index i>0 is operand bit i-1, so
  // after all levels g[i] is the carry into bit i.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p_orig;
    pfa_msb_t         msb;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic             w_adv;
  logic             w_accept;
  logic [WIDTH-1:0] w_beff;
  logic             w_c0;
  stage_t           w_sin  [STAGES];
  stage_t           w_sout [STAGES];
  logic [WIDTH-1:0] w_lg   [LEVELS];
  logic [WIDTH-1:0] w_lp   [LEVELS];
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_vnext;
  logic [WIDTH-1:0] w_s;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic [TAG_W-1:0] r_tag;

  assign w_adv    = out_ready || !r_valid[STAGES-1];
  assign in_ready = w_adv && !rst;
  assign w_accept = in_valid && in_ready;
  assign w_beff   = sub ? ~b : b;
  assign w_c0     = cin ^ sub;

  assign w_sin[0] = '{
    g:      {a[WIDTH-2:0] & w_beff[WIDTH-2:0], w_c0},
    p:      {a[WIDTH-2:0] ^ w_beff[WIDTH-2:0], 1'b0},
    p_orig: a ^ w_beff,
    msb:    pfa_msb_t'{a_msb: a[WIDTH-1], b_msb: w_beff[WIDTH-1]},
    tag:    in_tag
  };

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int STG = stage_of_level(l, LPS);
    logic [WIDTH-1:0] w_gi;
    logic [WIDTH-1:0] w_pi;
    if (l == STG * LPS) begin : g_first
      assign w_gi = w_sin[STG].g;
      assign w_pi = w_sin[STG].p;
    end else begin : g_chain
      assign w_gi = w_lg[l-1];
      assign w_pi = w_lp[l-1];
    end
    pfa_prefix_level #(.N(WIDTH), .DIST(1 << l)) u_lvl (
      .i_g(w_gi),
      .i_p(w_pi),
      .o_g(w_lg[l]),
      .o_p(w_lp[l])
    );
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    if (k * LPS < LEVELS) begin : g_lv
      localparam int LAST = (((k + 1) * LPS < LEVELS) ? (k + 1) * LPS : LEVELS) - 1;
      assign w_sout[k] = '{
        g:      w_lg[LAST],
        p:      w_lp[LAST],
        p_orig: w_sin[k].p_orig,
        msb:    w_sin[k].msb,
        tag:    w_sin[k].tag
      };
    end else begin : g_pass
      assign w_sout[k] = w_sin[k];
    end
    if (k < STAGES - 1) begin : g_reg
      stage_t r_pay;
      always_ff @(posedge clk) begin
        if (w_adv) r_pay <= w_sout[k];
      end
      assign w_sin[k+1] = r_pay;
    end
  end

  // Top-bit generate is a_msb & b_msb, so cout needs no extra prefix slot.
  assign w_s    = w_sout[STAGES-1].p_orig ^ w_sout[STAGES-1].g;
  assign w_cout = (w_sout[STAGES-1].msb.a_msb & w_sout[STAGES-1].msb.b_msb) |
                  (w_sout[STAGES-1].p_orig[WIDTH-1] & w_sout[STAGES-1].g[WIDTH-1]);
  assign w_ovf  = (w_sout[STAGES-1].msb.a_msb == w_sout[STAGES-1].msb.b_msb) &&
                  (w_s[WIDTH-1] != w_sout[STAGES-1].msb.a_msb);

  if (STAGES == 1) begin : g_v1
    assign w_vnext = w_accept;
  end else begin : g_vn
    assign w_vnext = {r_valid[STAGES-2:0], w_accept};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_tag   <= '0;
    end else if (w_adv) begin
      r_valid <= w_vnext;
      if (w_vnext[STAGES-1]) begin
        r_s    <= w_s;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_tag  <= w_sout[STAGES-1].tag;
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_tag   = r_tag;

endmodule

// File: tb/tb_pfa_pipe.sv
// tb/tb_pfa_pipe.sv - scoreboard bench for pfa_pipe over three parameter sets
module tb_pfa_pipe;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
    int          t;
    bit          exact;
  } exp_t;

  localparam int NI = 3;
  int wd [NI] = '{32, 8, 32};
  int sd [NI] = '{3, 4, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inv [NI];
  logic        ord [NI];
  logic        ci  [NI];
  logic        su  [NI];
  logic [63:0] av  [NI];
  logic [63:0] bv  [NI];
  logic [3:0]  tgi [NI];
  logic        ir  [NI];
  logic        ov  [NI];
  logic        co  [NI];
  logic        of  [NI];
  logic [3:0]  tgo [NI];
  logic [31:0] s0;
  logic [7:0]  s1;
  logic [31:0] s2;
  logic [63:0] so  [NI];

  exp_t q [NI][$];
  int   n_rx [NI];
  bit   lat_exact [NI];
  bit   rnd_on;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  assign so[0] = {32'h0, s0};
  assign so[1] = {56'h0, s1};
  assign so[2] = {32'h0, s2};

  pfa_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(inv[0]), .in_ready(ir[0]),
    .a(av[0][31:0]), .b(bv[0][31:0]), .cin(ci[0]), .sub(su[0]), .in_tag(tgi[0]),
    .out_valid(ov[0]), .out_ready(ord[0]), .s(s0), .cout(co[0]), .ovf(of[0]), .out_tag(tgo[0])
  );

  pfa_pipe #(.WIDTH(8), .STAGES(4), .TAG_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(inv[1]), .in_ready(ir[1]),
    .a(av[1][7:0]), .b(bv[1][7:0]), .cin(ci[1]), .sub(su[1]), .in_tag(tgi[1]),
    .out_valid(ov[1]), .out_ready(ord[1]), .s(s1), .cout(co[1]), .ovf(of[1]), .out_tag(tgo[1])
  );

  pfa_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(4)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(inv[2]), .in_ready(ir[2]),
    .a(av[2][31:0]), .b(bv[2][31:0]), .cin(ci[2]), .sub(su[2]), .in_tag(tgi[2]),
    .out_valid(ov[2]), .out_ready(ord[2]), .s(s2), .cout(co[2]), .ovf(of[2]), .out_tag(tgo[2])
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit arithmetic on the effective operands.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input logic sb, input logic [3:0] tg);
    exp_t        e;
    logic [64:0] m, am, beff, sum;
    m    = (65'd1 << w) - 65'd1;
    am   = {1'b0, a} & m;
    beff = sb ? (~{1'b0, b} & m) : ({1'b0, b} & m);
    sum  = am + beff + {64'd0, c ^ sb};
    e.s     = sum[63:0] & m[63:0];
    e.cout  = sum[w];
    e.ovf   = (am[w-1] == beff[w-1]) && (sum[w-1] != am[w-1]);
    e.tag   = tg;
    e.t     = 0;
    e.exact = 0;
    return e;
  endfunction

  task automatic send(input int k, input logic [63:0] a, input logic [63:0] b, input logic c,
                      input logic sb, input logic [3:0] tg, input bit dir,
                      input logic [63:0] es, input logic ec, input logic eo);
    exp_t e;
    int   n;
    av[k] = a; bv[k] = b; ci[k] = c; su[k] = sb; tgi[k] = tg; inv[k] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir[k]) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout%0d: in_ready stayed 0, required 1", k);
    end else begin
      e = model(wd[k], a, b, c, sb, tg);
      if (dir) begin
        e.s = es; e.cout = ec; e.ovf = eo;
      end
      e.t     = cyc;
      e.exact = lat_exact[k];
      q[k].push_back(e);
    end
    @(posedge clk);
    #1;
    inv[k] = 1'b0;
    av[k] = {$urandom, $urandom};
    bv[k] = {$urandom, $urandom};
    su[k] = 1'($urandom);
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (q[k].size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain%0d", k), 64'(q[k].size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beats(input int k, input int nb);
    logic [63:0] ra, rb;
    for (int i = 0; i < nb; i++) begin
      if ($urandom % 5 == 0) begin
        @(posedge clk);
        #1;
      end
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom % 8 == 0) ra = '1;
      if ($urandom % 8 == 0) rb = 64'd1;
      send(k, ra, rb, 1'($urandom), 1'($urandom), 4'($urandom), 1'b0, 64'd0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bit          hold [NI];
    logic [63:0] hs   [NI];
    logic        hc   [NI];
    logic        ho   [NI];
    logic [3:0]  ht   [NI];
    exp_t        e;
    int          lat;
    for (int k = 0; k < NI; k++) hold[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (rst) begin
          q[k].delete();
          hold[k] = 1'b0;
        end else begin
          if (hold[k]) begin
            chk($sformatf("hold_valid%0d", k), {63'd0, ov[k]}, 64'd1);
            chk($sformatf("hold_s%0d", k), so[k], hs[k]);
            chk($sformatf("hold_cout%0d", k), {63'd0, co[k]}, {63'd0, hc[k]});
            chk($sformatf("hold_ovf%0d", k), {63'd0, of[k]}, {63'd0, ho[k]});
            chk($sformatf("hold_tag%0d", k), {60'd0, tgo[k]}, {60'd0, ht[k]});
          end
          hold[k] = 1'b0;
          if (ov[k] && !ord[k]) begin
            chk($sformatf("stall_in_ready%0d", k), {63'd0, ir[k]}, 64'd0);
            hold[k] = 1'b1;
            hs[k] = so[k]; hc[k] = co[k]; ho[k] = of[k]; ht[k] = tgo[k];
          end
          if (ov[k] && ord[k]) begin
            if (q[k].size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_out%0d: got beat tag %h s %h, required no output", k, tgo[k], so[k]);
            end else begin
              e = q[k].pop_front();
              chk($sformatf("s%0d", k), so[k], e.s);
              chk($sformatf("cout%0d", k), {63'd0, co[k]}, {63'd0, e.cout});
              chk($sformatf("ovf%0d", k), {63'd0, of[k]}, {63'd0, e.ovf});
              chk($sformatf("tag%0d", k), {60'd0, tgo[k]}, {60'd0, e.tag});
              lat = cyc - e.t;
              if (e.exact) chk($sformatf("latency%0d", k), 64'(lat), 64'(sd[k]));
              else chk($sformatf("latency_min%0d", k), {63'd0, lat >= sd[k]}, 64'd1);
            end
            n_rx[k]++;
          end
        end
      end
    end
  end

  initial begin
    int n, r0;
    for (int k = 0; k < NI; k++) begin
      inv[k] = 1'b0; ord[k] = 1'b1; ci[k] = 1'b0; su[k] = 1'b0;
      av[k] = '0; bv[k] = '0; tgi[k] = '0; n_rx[k] = 0; lat_exact[k] = 1'b1;
    end
    rnd_on = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk($sformatf("rst_in_ready%0d", k), {63'd0, ir[k]}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {63'd0, ov[0]}, 64'd0);
    chk("reset_s", so[0], 64'd0);
    chk("reset_cout_ovf", {62'd0, co[0], of[0]}, 64'd0);
    chk("reset_tag", {60'd0, tgo[0]}, 64'd0);
    chk("reset_in_ready", {63'd0, ir[0]}, 64'd1);
    chk("reset_out_valid_b", {63'd0, ov[1]}, 64'd0);
    @(posedge clk);
    #1;

    send(0, 64'h00FF00FF, 64'hFF00FF00, 1'b0, 1'b0, 4'd0, 1'b1, 64'hFFFFFFFF, 1'b0, 1'b0);
    send(0, 64'hF3FF00FF, 64'h0C00FF00, 1'b1, 1'b0, 4'd0, 1'b1, 64'h00000000, 1'b1, 1'b0);
    send(0, 64'd5,        64'd7,        1'b0, 1'b1, 4'd1, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0);
    send(0, 64'h7FFFFFFF, 64'd1,        1'b0, 1'b0, 4'd2, 1'b1, 64'h80000000, 1'b0, 1'b1);
    send(0, 64'h80000000, 64'd1,        1'b0, 1'b1, 4'd3, 1'b1, 64'h7FFFFFFF, 1'b1, 1'b1);
    drain(0);

    lat_exact[0] = 1'b0;
    r0 = n_rx[0];
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
               4'(4 + i), 1'b0, 64'd0, 1'b0, 1'b0);
      end
      begin
        n = 0;
        while (!ov[0] && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_valid_seen", {63'd0, ov[0]}, 64'd1);
        @(posedge clk);
        #1 ord[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 ord[0] = 1'b1;
      end
    join
    drain(0);
    chk("bp_count", 64'(n_rx[0] - r0), 64'd6);

    lat_exact[0] = 1'b1;
    for (int i = 0; i < 3; i++)
      send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 4'(10 + i), 1'b0, 64'd0, 1'b0, 1'b0);
    rst = 1'b1;
    inv[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    inv[0] = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, ov[0]}, 64'd0);
    chk("midrst_s", so[0], 64'd0);
    r0 = n_rx[0];
    repeat (6) @(negedge clk);
    chk("midrst_no_output", 64'(n_rx[0] - r0), 64'd0);
    @(posedge clk);
    #1;
    send(0, 64'hFFFFFFFF, 64'd1, 1'b0, 1'b0, 4'd13, 1'b1, 64'h00000000, 1'b1, 1'b0);
    drain(0);

    send(1, 64'hFF, 64'h01, 1'b0, 1'b0, 4'd1, 1'b1, 64'h00, 1'b1, 1'b0);
    send(1, 64'h7F, 64'h01, 1'b0, 1'b0, 4'd2, 1'b1, 64'h80, 1'b0, 1'b1);
    drain(1);

    lat_exact[1] = 1'b0;
    lat_exact[2] = 1'b0;
    rnd_on = 1'b1;
    r0 = n_rx[1];
    fork
      begin
        fork
          rand_beats(1, 400);
          rand_beats(2, 10000);
        join
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          ord[1] = ($urandom % 3) != 0;
          ord[2] = ($urandom % 3) != 0;
        end
        ord[1] = 1'b1;
        ord[2] = 1'b1;
      end
    join
    drain(1);
    drain(2);
    chk("rand_count_b", 64'(n_rx[1] - r0), 64'd400);
    chk("rand_count_c", 64'(n_rx[2]), 64'd10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
